// File: rtl/dac_ramp_sequencer_if.sv
// ---------------------------------------------------------------------------
// dac_ramp_sequencer_if
// Target-code handshake between a code producer and dac_ramp_sequencer.
//   tgt_valid : producer offers a new target code
//   tgt_data  : 16-bit target DAC code
//   tgt_ready : sequencer can accept a target (IDLE only)
// A transfer happens on a rising clock edge with tgt_valid & tgt_ready high.
// ---------------------------------------------------------------------------
interface dac_ramp_sequencer_if;
  logic        tgt_valid;
  logic [15:0] tgt_data;
  logic        tgt_ready;

  modport master (
    output tgt_valid,
    output tgt_data,
    input  tgt_ready
  );

  modport slave (
    input  tgt_valid,
    input  tgt_data,
    output tgt_ready
  );
endinterface

// File: rtl/dac_ramp_sequencer.sv
// ---------------------------------------------------------------------------
// dac_ramp_sequencer
// Accepts a target DAC code and issues one or more write requests to a
// downstream DAC SPI writer until the output level reaches the target.
// Each write holds Ready/CMD_IN/DAC_DATAIN for FRAME_CYCLES clocks, then
// Ready stays low for GAP_CYCLES clocks before the next write or IDLE.
//
// Ports
//   clk_100M   in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   tgt        if   target handshake (slave side)
//   step_size  in   max code change per write (0 behaves as 1)
//   Ready      out  write request to the DAC writer
//   CMD_IN     out  16'd1 while a write is requested, else 16'd0
//   DAC_DATAIN out  code being written; holds last value when idle
//   busy       out  high in every state except IDLE
//   dac_code   out  last code issued
//
// Build option
//   DAC_RAMP_SLEW_EN : when defined, each write moves at most step_size
//                      toward the target. When undefined, the target is
//                      written in a single step and step_size is ignored.
// ---------------------------------------------------------------------------
module dac_ramp_sequencer #(
  parameter int FRAME_CYCLES = 96,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                       clk_100M,
  input  logic                       rst,
  dac_ramp_sequencer_if.slave        tgt,
  input  logic [15:0]                step_size,
  output logic                       Ready,
  output logic [15:0]                CMD_IN,
  output logic [15:0]                DAC_DATAIN,
  output logic                       busy,
  output logic [15:0]                dac_code
);

  localparam int CNT_MAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] FRAME_LAST    = CNT_W'(FRAME_CYCLES - 1);
  // The STEP cycle is itself a Ready-low cycle, so when another write follows
  // the GAP state is one cycle shorter and the low interval stays GAP_CYCLES.
  localparam logic [CNT_W-1:0] GAP_LAST_CONT = CNT_W'(GAP_CYCLES - 2);
  localparam logic [CNT_W-1:0] GAP_LAST_END  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO      = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    WRITE = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [15:0]      target_r, target_s;
  logic [15:0]      code_r, code_s;
  logic [15:0]      data_r, data_s;
  logic [15:0]      cmd_r, cmd_s;
  logic             ready_r, ready_s;
  logic             busy_r, busy_s;
  logic             tgt_ready_r, tgt_ready_s;
  logic [15:0]      next_code_s;
  logic             more_s;

`ifdef DAC_RAMP_SLEW_EN
  // Move code toward target by at most step; the 17-bit difference keeps
  // the comparison exact so the result never wraps past 0x0000 or 0xFFFF.
  function automatic logic [15:0] slew_next(
    input logic [15:0] code,
    input logic [15:0] target,
    input logic [15:0] step_raw
  );
    logic [15:0] step;
    logic [16:0] diff;
    logic [15:0] result;
    step = (step_raw == 16'd0) ? 16'd1 : step_raw;
    if (target >= code) begin
      diff = {1'b0, target} - {1'b0, code};
      if (diff <= {1'b0, step}) begin
        result = target;
      end else begin
        result = code + step;
      end
    end else begin
      diff = {1'b0, code} - {1'b0, target};
      if (diff <= {1'b0, step}) begin
        result = target;
      end else begin
        result = code - step;
      end
    end
    return result;
  endfunction

  // Next code for the upcoming write, limited by step_size.
  always_comb begin
    next_code_s = slew_next(code_r, target_r, step_size);
  end
`else
  logic unused_step_s;
  assign unused_step_s = ^step_size;

  // Next code for the upcoming write: jump straight to the target.
  always_comb begin
    next_code_s = target_r;
  end
`endif

  assign more_s = (code_r != target_r);

  // Next-state and next-output logic for the sequencer FSM.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    target_s = target_r;
    code_s   = code_r;
    data_s   = data_r;
    cmd_s    = cmd_r;
    ready_s  = ready_r;
    case (state_r)
      IDLE: begin
        if (tgt.tgt_valid) begin
          target_s = tgt.tgt_data;
          state_s  = STEP;
        end else begin
          state_s  = IDLE;
        end
      end
      STEP: begin
        code_s  = next_code_s;
        data_s  = next_code_s;
        cmd_s   = 16'd1;
        ready_s = 1'b1;
        cnt_s   = CNT_ZERO;
        state_s = WRITE;
      end
      WRITE: begin
        if (cnt_r == FRAME_LAST) begin
          cmd_s   = 16'd0;
          ready_s = 1'b0;
          cnt_s   = CNT_ZERO;
          state_s = GAP;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      GAP: begin
        if (more_s && (cnt_r == GAP_LAST_CONT)) begin
          cnt_s   = CNT_ZERO;
          state_s = STEP;
        end else if (!more_s && (cnt_r == GAP_LAST_END)) begin
          cnt_s   = CNT_ZERO;
          state_s = IDLE;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        cmd_s   = 16'd0;
        ready_s = 1'b0;
        cnt_s   = CNT_ZERO;
        state_s = IDLE;
      end
    endcase
    // Handshake flags are registered from the next state so they line up
    // with the state they describe.
    tgt_ready_s = (state_s == IDLE);
    busy_s      = (state_s != IDLE);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      target_r    <= 16'd0;
      code_r      <= 16'd0;
      data_r      <= 16'd0;
      cmd_r       <= 16'd0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      tgt_ready_r <= 1'b1;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      target_r    <= target_s;
      code_r      <= code_s;
      data_r      <= data_s;
      cmd_r       <= cmd_s;
      ready_r     <= ready_s;
      busy_r      <= busy_s;
      tgt_ready_r <= tgt_ready_s;
    end
  end

  assign tgt.tgt_ready = tgt_ready_r;
  assign Ready         = ready_r;
  assign CMD_IN        = cmd_r;
  assign DAC_DATAIN    = data_r;
  assign busy          = busy_r;
  assign dac_code      = code_r;

endmodule
